// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the CPU run/step/reset controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } run_state_e;

  localparam int unsigned RST_STRETCH_DEF = 16;
  localparam int unsigned DEBOUNCE_DEF    = 4;
  localparam int unsigned STEP_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF       = 32;

endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchroniser plus run-length debounce for a raw button.
// Emits a one-cycle registered pulse when the debounced level rises.
module btn_debounce
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] run_cnt;

  // Level flips on the DEBOUNCE-th consecutive differing sample; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      run_cnt <= '0;
      rise    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        level   <= sync2;
        run_cnt <= '0;
        rise    <= sync2;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/run_step_ctrl.sv
// CPU run/step/reset controller: reset stretcher, debounced single/multi-step bursts,
// debug halt switch and a retired-cycle counter.
module run_step_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RST_STRETCH = RST_STRETCH_DEF,
  parameter int unsigned DEBOUNCE    = DEBOUNCE_DEF,
  parameter int unsigned STEP_W      = STEP_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold_rst,
  input  logic              debug_en,
  input  logic              step_btn,
  input  logic [STEP_W-1:0] step_count,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned SW = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(RST_STRETCH);

  run_state_e        state;
  logic [SW-1:0]     stretch;
  logic [STEP_W-1:0] burst;
  logic [STEP_W-1:0] burst_len;
  logic              dbg_sync1;
  logic              dbg_sync2;
  logic              step_rise;

  assign burst_len = (step_count == '0) ? STEP_W'(1) : step_count;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk  (clk),
    .rstn (rstn),
    .btn  (step_btn),
    .rise (step_rise)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_sync1 <= 1'b0;
      dbg_sync2 <= 1'b0;
    end else begin
      dbg_sync1 <= debug_en;
      dbg_sync2 <= dbg_sync1;
    end
  end

  // Outputs are updated together with the state so they always match the state they decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_RESET;
      stretch <= STRETCH_LOAD;
      burst   <= '0;
      cpu_rst <= 1'b1;
      cpu_en  <= 1'b0;
      busy    <= 1'b0;
    end else if (hold_rst) begin
      state   <= ST_RESET;
      stretch <= STRETCH_LOAD;
      cpu_rst <= 1'b1;
      cpu_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (stretch == '0) begin
            cpu_rst <= 1'b0;
            if (dbg_sync2) begin
              state <= ST_HALT;
            end else begin
              state  <= ST_RUN;
              cpu_en <= 1'b1;
            end
          end else begin
            stretch <= stretch - SW'(1);
          end
        end
        ST_RUN: begin
          if (dbg_sync2) begin
            state  <= ST_HALT;
            cpu_en <= 1'b0;
          end
        end
        ST_HALT: begin
          // A step edge beats a simultaneous switch back to free run.
          if (step_rise) begin
            state  <= ST_STEP;
            burst  <= burst_len;
            cpu_en <= 1'b1;
            busy   <= 1'b1;
          end else if (!dbg_sync2) begin
            state  <= ST_RUN;
            cpu_en <= 1'b1;
          end
        end
        ST_STEP: begin
          if (burst == STEP_W'(1)) begin
            busy <= 1'b0;
            if (dbg_sync2) begin
              state  <= ST_HALT;
              cpu_en <= 1'b0;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            burst <= burst - STEP_W'(1);
          end
        end
        default: begin
          state   <= ST_RESET;
          stretch <= STRETCH_LOAD;
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule
